// File: rtl/servile_wb_uart_tx.sv
// servile_wb_uart_tx: Wishbone UART transmitter (TXDATA/STATUS/DIV registers at adr[3:2]=0/1/2, FWFT TX FIFO, 8N1 serial on o_tx)
module servile_wb_uart_tx #(
  parameter logic [15:0] CLK_DIV = 16'd104,
  parameter int FIFO_AW = 2
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic [31:0] i_wb_adr,
  input  logic [31:0] i_wb_dat,
  input  logic [3:0]  i_wb_sel,
  input  logic        i_wb_we,
  input  logic        i_wb_stb,
  output logic [31:0] o_wb_rdt,
  output logic        o_wb_ack,
  output logic        o_tx
);
  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;
  state_t state, state_n;
  logic [15:0] div, cnt, cnt_n, load;
  logic [2:0] bitn, bitn_n;
  logic [7:0] sh, sh_n;
  logic [7:0] mem [2**FIFO_AW];
  logic [FIFO_AW:0] wp, rp;
  logic [1:0] a;
  logic [31:0] rdata;
  logic acc, push, pop, full, empty, busy, bit_end, tx_n;
  logic ovf;
  logic unused;
  assign unused = ^{i_wb_adr[31:4], i_wb_adr[1:0], i_wb_dat[31:16], i_wb_sel[3:2]};
  assign a = i_wb_adr[3:2];
  assign acc = i_wb_stb & ~o_wb_ack;
  assign push = acc & i_wb_we & (a == 2'd0) & i_wb_sel[0];
  assign empty = wp == rp;
  assign full = (wp[FIFO_AW] != rp[FIFO_AW]) & (wp[FIFO_AW-1:0] == rp[FIFO_AW-1:0]);
  assign busy = state != IDLE;
  assign bit_end = cnt == 16'd0;
  assign load = div == 16'd0 ? 16'd0 : div - 16'd1;
  assign rdata = a == 2'd1 ? {28'd0, ovf, busy, empty, full} : a == 2'd2 ? {16'd0, div} : 32'd0;
  always_ff @(posedge i_clk)
    if (i_rst) begin
      o_wb_ack <= 1'b0;
      o_wb_rdt <= 32'd0;
      div <= CLK_DIV;
      ovf <= 1'b0;
      wp <= '0;
    end else begin
      o_wb_ack <= acc;
      o_wb_rdt <= acc & ~i_wb_we ? rdata : 32'd0;
      if (push & full)
        ovf <= 1'b1;
      else if (acc & i_wb_we & (a == 2'd1) & i_wb_sel[0] & i_wb_dat[3])
        ovf <= 1'b0;
      if (push & ~full)
        wp <= wp + {{FIFO_AW{1'b0}}, 1'b1};
      if (acc & i_wb_we & (a == 2'd2)) begin
        if (i_wb_sel[0])
          div[7:0] <= i_wb_dat[7:0];
        if (i_wb_sel[1])
          div[15:8] <= i_wb_dat[15:8];
      end
    end
  always_ff @(posedge i_clk)
    if (~i_rst & push & ~full)
      mem[wp[FIFO_AW-1:0]] <= i_wb_dat[7:0];
  always_comb begin
    state_n = state;
    cnt_n = cnt - 16'd1;
    bitn_n = bitn;
    sh_n = sh;
    tx_n = o_tx;
    pop = 1'b0;
    if (state == IDLE || bit_end) begin
      cnt_n = load;
      case (state)
        START: begin
          state_n = DATA;
          bitn_n = 3'd0;
          tx_n = sh[0];
        end
        DATA: begin
          state_n = bitn == 3'd7 ? STOP : DATA;
          bitn_n = bitn + 3'd1;
          sh_n = sh >> 1;
          tx_n = bitn == 3'd7 ? 1'b1 : sh[1];
        end
        default: begin
          pop = ~empty;
          state_n = empty ? IDLE : START;
          cnt_n = empty ? 16'd0 : load;
          sh_n = empty ? sh : mem[rp[FIFO_AW-1:0]];
          tx_n = empty;
        end
      endcase
    end
  end
  always_ff @(posedge i_clk)
    if (i_rst) begin
      state <= IDLE;
      cnt <= 16'd0;
      bitn <= 3'd0;
      sh <= 8'd0;
      o_tx <= 1'b1;
      rp <= '0;
    end else begin
      state <= state_n;
      cnt <= cnt_n;
      bitn <= bitn_n;
      sh <= sh_n;
      o_tx <= tx_n;
      if (pop)
        rp <= rp + {{FIFO_AW{1'b0}}, 1'b1};
    end
endmodule

// File: tb/tb_servile_wb_uart_tx.sv
// tb_servile_wb_uart_tx: directed table-driven bench for the Wishbone UART transmitter
module tb_servile_wb_uart_tx;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic we = 1'b0;
  logic stb = 1'b0;
  logic [31:0] adr = 32'd0;
  logic [31:0] dat = 32'd0;
  logic [3:0] sel = 4'd0;
  logic [31:0] rdt;
  logic ack, tx;
  int ncmp = 0;
  int nfail = 0;
  logic [7:0] stream [8];
  typedef struct {
    logic we;
    logic [31:0] adr;
    logic [31:0] dat;
    logic [3:0] sel;
    logic c;
    logic [31:0] exp;
  } vec_t;
  vec_t tbl [18];
  always #5 clk = ~clk;
  servile_wb_uart_tx dut (
    .i_clk(clk), .i_rst(rst), .i_wb_adr(adr), .i_wb_dat(dat), .i_wb_sel(sel),
    .i_wb_we(we), .i_wb_stb(stb), .o_wb_rdt(rdt), .o_wb_ack(ack), .o_tx(tx)
  );
  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    ncmp++;
    if (got !== exp) begin
      nfail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, got, exp);
    end
  endtask
  task automatic wb(input logic w, input logic [31:0] a, input logic [31:0] d, input logic [3:0] s, output logic [31:0] r);
    int n = 0;
    @(negedge clk);
    stb = 1'b1;
    we = w;
    adr = a;
    dat = d;
    sel = s;
    do begin
      @(negedge clk);
      n++;
    end while (!ack && n < 8);
    if (!ack)
      chk("wb_ack_timeout", {31'd0, ack}, 32'd1);
    r = rdt;
    stb = 1'b0;
    we = 1'b0;
  endtask
  task automatic check_stream(input int n, input int d, output int lat);
    int bad = -1;
    int b;
    logic e;
    logic gbad = 1'b0;
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
    end while (tx && lat < 64);
    if (tx) begin
      chk("tx_start_timeout", {31'd0, tx}, 32'd0);
      return;
    end
    for (int k = 0; k < n * 10 * d; k++) begin
      if (k > 0)
        @(negedge clk);
      b = (k / d) % 10;
      if (b == 0)
        e = 1'b0;
      else if (b == 9)
        e = 1'b1;
      else
        e = stream[k / (10 * d)][b - 1];
      if (tx !== e && bad < 0) begin
        bad = k;
        gbad = tx;
      end
    end
    ncmp++;
    if (bad >= 0) begin
      nfail++;
      $display("FAIL tx_stream: sample %0d got %b expected %b", bad, gbad, ~gbad);
    end
    @(negedge clk);
    chk("tx_idle_after_stream", {31'd0, tx}, 32'd1);
  endtask
  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
  initial begin
    logic [31:0] r;
    int lat;
    logic [3:0] pat;
    int low;
    tbl[0]  = '{1'b0, 32'h8,    32'h0,        4'hf, 1'b1, 32'h68};
    tbl[1]  = '{1'b0, 32'h4,    32'h0,        4'hf, 1'b1, 32'h2};
    tbl[2]  = '{1'b0, 32'h0,    32'h0,        4'hf, 1'b1, 32'h0};
    tbl[3]  = '{1'b0, 32'hc,    32'h0,        4'hf, 1'b1, 32'h0};
    tbl[4]  = '{1'b1, 32'h8,    32'h1234,     4'hf, 1'b0, 32'h0};
    tbl[5]  = '{1'b0, 32'h8,    32'h0,        4'hf, 1'b1, 32'h1234};
    tbl[6]  = '{1'b1, 32'h8,    32'hABCD,     4'h2, 1'b0, 32'h0};
    tbl[7]  = '{1'b0, 32'h8,    32'h0,        4'hf, 1'b1, 32'hAB34};
    tbl[8]  = '{1'b1, 32'h8,    32'h00EF,     4'h1, 1'b0, 32'h0};
    tbl[9]  = '{1'b0, 32'h8,    32'h0,        4'hf, 1'b1, 32'hABEF};
    tbl[10] = '{1'b1, 32'hc,    32'hFFFFFFFF, 4'hf, 1'b0, 32'h0};
    tbl[11] = '{1'b0, 32'h1008, 32'h0,        4'hf, 1'b1, 32'hABEF};
    tbl[12] = '{1'b1, 32'h8,    32'h0,        4'h0, 1'b0, 32'h0};
    tbl[13] = '{1'b0, 32'h8,    32'h0,        4'hf, 1'b1, 32'hABEF};
    tbl[14] = '{1'b1, 32'h0,    32'h5A,       4'he, 1'b0, 32'h0};
    tbl[15] = '{1'b0, 32'h4,    32'h0,        4'hf, 1'b1, 32'h2};
    tbl[16] = '{1'b1, 32'h8,    32'h4,        4'hf, 1'b0, 32'h0};
    tbl[17] = '{1'b0, 32'h8,    32'h0,        4'hf, 1'b1, 32'h4};
    repeat (3) @(negedge clk);
    chk("rst_ack", {31'd0, ack}, 32'd0);
    chk("rst_tx", {31'd0, tx}, 32'd1);
    chk("rst_rdt", rdt, 32'd0);
    rst = 1'b0;
    for (int i = 0; i < 18; i++) begin
      wb(tbl[i].we, tbl[i].adr, tbl[i].dat, tbl[i].sel, r);
      if (tbl[i].c)
        chk($sformatf("vec%0d", i), r, tbl[i].exp);
    end
    stream[0] = 8'h55;
    wb(1'b1, 32'h0, 32'h55, 4'h1, r);
    chk("tx_high_at_accept", {31'd0, tx}, 32'd1);
    check_stream(1, 4, lat);
    chk("tx_latency", lat, 32'd1);
    wb(1'b0, 32'h4, 32'h0, 4'hf, r);
    chk("status_idle_a", r, 32'h2);
    wb(1'b1, 32'h8, 32'h2, 4'hf, r);
    for (int i = 0; i < 5; i++)
      stream[i] = 8'(i + 1);
    fork
      begin
        logic [31:0] rb;
        for (int i = 0; i < 5; i++)
          wb(1'b1, 32'h0, 32'(i + 1), 4'h1, rb);
        wb(1'b0, 32'h4, 32'h0, 4'hf, rb);
        chk("status_b_full", rb, 32'h5);
      end
      begin
        int lb;
        check_stream(5, 2, lb);
      end
    join
    wb(1'b1, 32'h8, 32'h8, 4'hf, r);
    for (int i = 0; i < 5; i++)
      stream[i] = 8'(8'h11 * (i + 1));
    fork
      begin
        logic [31:0] rc;
        for (int i = 0; i < 5; i++)
          wb(1'b1, 32'h0, 32'(8'h11 * (i + 1)), 4'h1, rc);
        wb(1'b0, 32'h4, 32'h0, 4'hf, rc);
        chk("status_c_full", rc, 32'h5);
        wb(1'b1, 32'h0, 32'h66, 4'h1, rc);
        wb(1'b0, 32'h4, 32'h0, 4'hf, rc);
        chk("status_c_ovf", rc, 32'hD);
        wb(1'b1, 32'h4, 32'h8, 4'h1, rc);
        wb(1'b0, 32'h4, 32'h0, 4'hf, rc);
        chk("status_c_ovf_clr", rc, 32'h5);
      end
      begin
        int lc;
        check_stream(5, 8, lc);
      end
    join
    wb(1'b0, 32'h4, 32'h0, 4'hf, r);
    chk("status_idle_c", r, 32'h2);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    wb(1'b0, 32'h8, 32'h0, 4'hf, r);
    chk("div_after_reset", r, 32'h68);
    wb(1'b1, 32'h8, 32'h0, 4'h3, r);
    stream[0] = 8'hFF;
    wb(1'b1, 32'h0, 32'hFF, 4'h1, r);
    check_stream(1, 1, lat);
    chk("tx_latency_div0", lat, 32'd1);
    wb(1'b1, 32'h8, 32'h4, 4'hf, r);
    wb(1'b1, 32'h0, 32'hA5, 4'h1, r);
    repeat (10) @(negedge clk);
    chk("tx_mid_data", {31'd0, tx}, 32'd0);
    rst = 1'b1;
    stb = 1'b1;
    we = 1'b1;
    adr = 32'h8;
    dat = 32'h5;
    sel = 4'hf;
    @(negedge clk);
    chk("ack_in_reset", {31'd0, ack}, 32'd0);
    chk("tx_after_reset", {31'd0, tx}, 32'd1);
    rst = 1'b0;
    stb = 1'b0;
    we = 1'b0;
    wb(1'b0, 32'h4, 32'h0, 4'hf, r);
    chk("status_after_reset", r, 32'h2);
    wb(1'b0, 32'h8, 32'h0, 4'hf, r);
    chk("div_ignored_in_reset", r, 32'h68);
    low = 0;
    for (int k = 0; k < 60; k++) begin
      @(negedge clk);
      if (!tx)
        low++;
    end
    chk("no_residual_frame", low, 32'd0);
    @(negedge clk);
    stb = 1'b1;
    we = 1'b0;
    adr = 32'h4;
    sel = 4'hf;
    pat = 4'd0;
    for (int k = 0; k < 4; k++) begin
      pat[k] = ack;
      if (ack)
        chk($sformatf("held_stb_rdt%0d", k), rdt, 32'h2);
      @(negedge clk);
    end
    stb = 1'b0;
    chk("held_stb_ack_pattern", {28'd0, pat}, 32'b1010);
    chk("held_stb_ack_end", {31'd0, ack}, 32'd0);
    @(negedge clk);
    chk("held_stb_ack_idle", {31'd0, ack}, 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
    $finish;
  end
endmodule
